// File: rtl/mips_io_pkg.sv
// Shared encodings and constants for the MIPS core I/O stages.
// UART_TX_PARITY_EN (optional define) adds an even-parity bit to each UART frame.
package mips_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-time timer: counts 0..BAUD_DIV-1 and pulses Tick on the wrap cycle.
// Restart holds the count at 0 so the next period starts cleanly.
module baud_tick_gen
  #(parameter int BAUD_DIV = 434)
  (
    input  logic clk,
    input  logic reset,
    input  logic Restart,
    output logic Tick
  );

  localparam int CW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (Restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Tick = !Restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx_port.sv
// Serializes one 32-bit output-port word into NUM_BYTES 8N1 UART frames, byte 0 first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state     | meaning
// ST_IDLE   | line high, WrReady high, waiting for a word
// ST_START  | start bit (low) of the current byte
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even parity of the byte (only with UART_TX_PARITY_EN)
// ST_STOP   | stop bit (high); then next byte or back to idle
module uart_tx_port
  import mips_io_pkg::*;
  #(
    parameter int BAUD_DIV   = 434,
    parameter int NUM_BYTES  = 4,
    parameter int DATA_WIDTH = 32
  )
  (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  WrValid,
    output logic                  WrReady,
    output logic                  Tx,
    output logic                  Busy,
    output logic [2:0]            BytesLeft
  );

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("uart_tx_port: BAUD_DIV must be >= 2");
    end
    if ((NUM_BYTES < 1) || (NUM_BYTES > 4)) begin : g_bad_bytes
      $error("uart_tx_port: NUM_BYTES must be in 1..4");
    end
    if (DATA_WIDTH != 8 * 4) begin : g_bad_width
      $error("uart_tx_port: DATA_WIDTH must be 32");
    end
  endgenerate

  uart_state_t                 state;
  logic [DATA_WIDTH-1:0]       word_q;
  logic [UART_DATA_BITS-2:0]   shreg;
  logic [2:0]                  bit_cnt;
  logic                        tick;
  logic                        restart;

  // Every non-idle state lasts whole baud periods, so the counter wrap doubles
  // as the state-entry restart; only idle needs to hold it at zero.
  assign restart = (state == ST_IDLE);

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .Restart (restart),
    .Tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      word_q    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      Tx        <= UART_IDLE_LEVEL;
      WrReady   <= 1'b1;
      Busy      <= 1'b0;
      BytesLeft <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (WrValid && WrReady) begin
            word_q    <= DataIn;
            state     <= ST_START;
            Tx        <= UART_START_LEVEL;
            WrReady   <= 1'b0;
            Busy      <= 1'b1;
            BytesLeft <= 3'(NUM_BYTES);
          end
        end

        ST_START: begin
          if (tick) begin
            state   <= ST_DATA;
            Tx      <= word_q[0];
            shreg   <= word_q[UART_DATA_BITS-1:1];
            bit_cnt <= '0;
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              Tx    <= even_parity(word_q[UART_DATA_BITS-1:0]);
`else
              state <= ST_STOP;
              Tx    <= UART_IDLE_LEVEL;
`endif
            end else begin
              Tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            Tx    <= UART_IDLE_LEVEL;
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            BytesLeft <= BytesLeft - 3'd1;
            word_q    <= word_q >> UART_DATA_BITS;
            if (BytesLeft == 3'd1) begin
              state   <= ST_IDLE;
              WrReady <= 1'b1;
              Busy    <= 1'b0;
            end else begin
              state <= ST_START;
              Tx    <= UART_START_LEVEL;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          Tx        <= UART_IDLE_LEVEL;
          WrReady   <= 1'b1;
          Busy      <= 1'b0;
          BytesLeft <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port: a line monitor decodes frames cycle by cycle
// against a byte scoreboard filled at each accepted word.
module tb_uart_tx_port;

  localparam int BAUD = 4;
  localparam int NB   = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int WORD_CYC = NB * FRAME * BAUD;

  typedef struct {
    logic [7:0] b;
    int         gap;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] DataIn;
  logic        WrValid;
  logic        WrReady;
  logic        Tx;
  logic        Busy;
  logic [2:0]  BytesLeft;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   idle_run = 1000;

  uart_tx_port #(.BAUD_DIV(BAUD), .NUM_BYTES(NB), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .DataIn    (DataIn),
    .WrValid   (WrValid),
    .WrReady   (WrReady),
    .Tx        (Tx),
    .Busy      (Busy),
    .BytesLeft (BytesLeft)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a word and hold it until accepted; returns the acceptance edge time.
  task automatic send_word(input logic [31:0] w, input int gap0, input bit hold, output time t_acc);
    bit   rdy;
    bit   done;
    exp_t e;
    done    = 1'b0;
    t_acc   = 0;
    DataIn  = w;
    WrValid = 1'b1;
    for (int n = 0; n < 4 * WORD_CYC; n++) begin
      rdy = (WrReady === 1'b1);
      @(posedge clk);
      if (rdy) begin
        t_acc = $time;
        for (int i = 0; i < NB; i++) begin
          e.b   = w[8*i +: 8];
          e.gap = (i == 0) ? gap0 : 0;
          sb.push_back(e);
        end
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (!hold) begin
      WrValid = 1'b0;
      DataIn  = 32'hFFFF_FFFF;
    end
  endtask

  task automatic wait_ready(output time t);
    int n;
    n = 0;
    while ((WrReady !== 1'b1) && (n < 4 * WORD_CYC)) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, WrReady}, 32'd1);
    t = $time;
  endtask

  // Line monitor: every sample of every bit of every frame is compared.
  initial begin : line_mon
    exp_t       e;
    logic [10:0] fb;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        idle_run = 1000;
        continue;
      end
      if (Tx !== 1'b0) begin
        idle_run++;
        continue;
      end
      if (sb.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
        repeat (FRAME * BAUD - 1) @(negedge clk);
        idle_run = 0;
        continue;
      end
      e = sb.pop_front();
      if (e.gap >= 0) chk($sformatf("frame_gap_byte%02h", e.b), idle_run, e.gap);
      fb = '0;
      for (int i = 0; i < 8; i++) fb[i+1] = e.b[i];
      if (FRAME == 11) fb[9] = ^e.b;
      fb[FRAME-1] = 1'b1;
      aborted = 1'b0;
      for (int k = 0; k < FRAME && !aborted; k++) begin
        for (int c = 0; c < BAUD && !aborted; c++) begin
          if ((k != 0) || (c != 0)) @(negedge clk);
          if (reset !== 1'b1) aborted = 1'b1;
          else chk($sformatf("bit%0d_byte%02h", k, e.b), {31'd0, Tx}, {31'd0, fb[k]});
        end
      end
      idle_run = aborted ? 1000 : 0;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    time t1, t2, t3;
    int  lows;
    reset   = 1'b0;
    WrValid = 1'b0;
    DataIn  = '0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'd0, Tx},      32'd1);
    chk("rst_ready", {31'd0, WrReady}, 32'd1);
    chk("rst_busy",  {31'd0, Busy},    32'd0);
    chk("rst_left",  {29'd0, BytesLeft}, 32'd0);
    reset = 1'b1;
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (Tx !== 1'b1) lows++;
    end
    chk("idle_line_lows", lows, 32'd0);

    // single word, DataIn scrambled after acceptance
    @(negedge clk);
    send_word(32'h0000_0AA5, -1, 1'b0, t1);
    chk("acc_busy",  {31'd0, Busy},      32'd1);
    chk("acc_ready", {31'd0, WrReady},   32'd0);
    chk("acc_left",  {29'd0, BytesLeft}, NB);
    chk("acc_tx",    {31'd0, Tx},        32'd0);
    repeat (42) @(negedge clk);
    chk("left_byte1", {29'd0, BytesLeft}, NB - 1);
    wait_ready(t2);
    chk("word_latency", int'((t2 - t1 - 5) / 10), WORD_CYC);
    chk("idle_busy", {31'd0, Busy},      32'd0);
    chk("idle_left", {29'd0, BytesLeft}, 32'd0);
    chk("idle_tx",   {31'd0, Tx},        32'd1);
    chk("sb_empty_single", sb.size(), 32'd0);

    // back-to-back words with WrValid held
    send_word(32'h1122_3344, -1, 1'b1, t1);
    send_word(32'h5566_7788, 1, 1'b0, t2);
    chk("b2b_accept_spacing", int'((t2 - t1) / 10), WORD_CYC + 1);
    wait_ready(t3);
    chk("b2b_latency", int'((t3 - t2 - 5) / 10), WORD_CYC);
    chk("sb_empty_b2b", sb.size(), 32'd0);

    // stall: word offered while busy must wait for the first ready cycle
    send_word(32'h0102_0304, -1, 1'b0, t1);
    repeat (20) @(negedge clk);
    send_word(32'hDEAD_BEEF, 1, 1'b0, t2);
    chk("stall_accept_spacing", int'((t2 - t1) / 10), WORD_CYC + 1);
    wait_ready(t3);
    chk("stall_latency", int'((t3 - t2 - 5) / 10), WORD_CYC);
    chk("sb_empty_stall", sb.size(), 32'd0);

    // reset in the middle of byte 1 data bits
    send_word(32'h1234_5678, -1, 1'b0, t1);
    repeat (50) @(negedge clk);
    chk("midrst_left_before", {29'd0, BytesLeft}, NB - 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_tx_async",    {31'd0, Tx},        32'd1);
    chk("midrst_ready_async", {31'd0, WrReady},   32'd1);
    chk("midrst_busy_async",  {31'd0, Busy},      32'd0);
    chk("midrst_left_async",  {29'd0, BytesLeft}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (Tx !== 1'b1) lows++;
    end
    chk("postrst_line_lows", lows, 32'd0);
    chk("postrst_ready", {31'd0, WrReady}, 32'd1);
    chk("postrst_busy",  {31'd0, Busy},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
